store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered store entries (power of two, >= 2).
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 cpu_we  in  1  store request from pipeline memory stage.
REQ-005 cpu_addr  in  32  store byte address; word-aligned, bits [1:0] ignored.
REQ-006 cpu_wdata  in  32  store data word.
REQ-007 cpu_stall  out  1  store not accepted this cycle; pipeline holds the store.
REQ-008 ld_addr  in  32  load address from memory stage, used for forwarding.
REQ-009 fwd_hit  out  1  ld_addr matches a buffered store.
REQ-010 fwd_data  out  32  data of the youngest matching buffered store.
REQ-011 mem_we  out  1  write request to data memory.
REQ-012 mem_addr  out  32  write address to data memory.
REQ-013 mem_wdata  out  32  write data to data memory.
REQ-014 mem_ready  in  1  data memory accepts the write this cycle.
REQ-015 empty  out  1  no buffered stores; software fence and end-of-test drain indicator.

Function
REQ-016 Storage: circular FIFO of DEPTH entries {valid, addr[31:2], data[31:0]}, with head pointer, tail pointer and a count of 0..DEPTH.
REQ-017 Full condition: count == DEPTH. Empty condition: count == 0. The empty output is registered-state derived, with no combinational input path.
REQ-018 Enqueue occurs when cpu_we=1 and the buffer is not full: write the entry at tail, set valid, tail = tail+1 mod DEPTH.
REQ-019 cpu_stall = cpu_we AND full, combinational. There is no full-bypass: a store presented while full stalls even if a drain completes in the same cycle.
REQ-020 Drain: mem_we = NOT empty; mem_addr = {head.addr, 2'b00}; mem_wdata = head.data; all driven from registered state.
REQ-021 Dequeue occurs when mem_we=1 and mem_ready=1: clear valid at head, head = head+1 mod DEPTH.
REQ-022 When enqueue and dequeue occur in the same cycle, count is unchanged; on an empty buffer only the enqueue is possible, because mem_we=0.
REQ-023 Latency: a store accepted at edge N appears on mem_we/mem_addr/mem_wdata after edge N when the buffer was empty. With mem_ready=1 continuously, entry k drains k cycles later.
REQ-024 Stores reach memory in acceptance order; no coalescing, reordering or dropping.
REQ-025 Forwarding compare is combinational: ld_addr[31:2] against addr of every valid entry.
REQ-026 When forwarding matches, fwd_hit=1 and fwd_data is taken from the youngest match, i.e. the entry closest to tail-1 in circular order.
REQ-027 When forwarding finds no match, fwd_hit=0 and fwd_data=0.
REQ-028 The head entry remains forwardable during the cycle it is dequeued.
REQ-029 A store being enqueued in the current cycle is not forwarded until the next cycle.
REQ-030 Pointer wrap-around from DEPTH-1 to 0 has no effect on ordering or forwarding priority.
REQ-031 mem_ready is ignored while mem_we=0.
REQ-032 mem_we, mem_addr and mem_wdata hold stable while mem_we=1 and mem_ready=0.

Reset
REQ-033 While reset=1: head=tail=0, count=0, all valid bits cleared; entry addr/data need not be cleared.
REQ-034 Output values during and after reset: mem_we=0, mem_addr=0, mem_wdata=0, empty=1, fwd_hit=0, fwd_data=0, cpu_stall=cpu_we AND 0=0.
REQ-035 Reset asserted mid-drain discards all pending stores. mem_we falls asynchronously with reset; no partial write is reissued after reset.

Verification
REQ-036 Single store: cpu_we=1, cpu_addr=0x00000010, cpu_wdata=0xDEADBEEF for 1 cycle, mem_ready=1 -> next cycle mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; the cycle after, empty=1.
REQ-037 Fill and stall: mem_ready=0, present 5 stores to 0x0,0x4,0x8,0xC,0x10 back-to-back. Required response: the first 4 are accepted; cpu_stall=1 on the 5th, count=4. Then raise mem_ready=1: the 5th store is accepted on the cycle after the first drain, and memory writes arrive in order 0x0,0x4,0x8,0xC,0x10.
REQ-038 Forwarding priority: mem_ready=0, store 0x20<-0x11111111 then 0x20<-0x22222222, then ld_addr=0x22 -> fwd_hit=1, fwd_data=0x22222222; ld_addr=0x24 -> fwd_hit=0, fwd_data=0.
REQ-039 Simultaneous push/pop with wrap: mem_ready=1 and a continuous store stream for 10 cycles (DEPTH=4). Required response: count stays at 1, cpu_stall never asserts, and memory receives 10 writes in order across pointer wrap.
REQ-040 Reset mid-drain: 3 stores buffered, mem_ready=0, assert reset for 1 cycle -> mem_we=0 immediately, empty=1, fwd_hit=0 for the prior addresses, and no memory writes after reset release.

Source files
------------

// File: rtl/store_buffer.sv
// Write-back store buffer: a circular FIFO of pending stores that drains to data
// memory in acceptance order and forwards the youngest matching store to loads.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  input  logic [31:0] ld_addr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  valid;
  logic [29:0]       addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic full;
  logic enq;
  logic deq;

  // Byte-offset bits are architecturally ignored for word stores and loads.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[1:0], ld_addr[1:0]};

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // No full-bypass: a drain completing this cycle does not free a slot for a
  // store presented in the same cycle.
  assign cpu_stall = cpu_we & full;
  assign enq       = cpu_we & ~full;

  assign mem_we    = ~empty;
  assign deq       = mem_we & mem_ready;

  // Gated with empty so stale entry contents never leak onto the memory bus.
  assign mem_addr  = empty ? '0 : {addr_q[head], 2'b00};
  assign mem_wdata = empty ? '0 : data_q[head];

  // Control state: pointers, occupancy and valid bits.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (enq) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      if (deq) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      unique case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload array is deliberately not reset; valid bits and count
  // alone decide what is live, so clearing wide storage buys nothing.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= cpu_addr[31:2];
      data_q[tail] <= cpu_wdata;
    end
  end

  // Scan oldest to youngest from head so the last hit is the youngest store,
  // independent of where the pointers currently sit in the ring.
  // NOTE: every output of this always_comb gets a default first so no latch
  // is inferred when nothing matches.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && (addr_q[idx] == ld_addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: table-driven single-cycle vectors plus
// hand-written fill/stall, streaming wrap-around and reset-mid-drain sequences.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        empty;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] wr_log [$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .ld_addr   (ld_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .empty     (empty)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] ld;
    logic        stall;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        emp;
    logic        hit;
    logic [31:0] fwd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Record any write memory accepts at this edge, then advance one cycle.
  task automatic tick();
    if (!reset && mem_we && mem_ready) wr_log.push_back({mem_addr, mem_wdata});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic [31:0] ld);
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    mem_ready = rdy;
    ld_addr   = ld;
  endtask

  task automatic check_log(input string name, input int idx, input logic [31:0] a,
                           input logic [31:0] d);
    if (idx < wr_log.size()) begin
      check({name, ".addr"}, wr_log[idx][63:32], a);
      check({name, ".data"}, wr_log[idx][31:0], d);
    end else begin
      check({name, ".present"}, 32'(idx), 32'(wr_log.size()));
    end
  endtask

  vec_t vecs[11];

  initial begin
    // we  addr          wdata         rdy ld            stall mwe maddr         mwdata        emp hit fwd
    vecs[0]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h10,       32'hDEADBEEF, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h10, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h20,       32'h11111111, 1'b0, 32'h22, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h20,       32'h22222222, 1'b0, 32'h22, 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0, 1'b1, 32'h11111111};
    vecs[6]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h22, 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0, 1'b1, 32'h22222222};
    vecs[7]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h24, 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h20, 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0, 1'b1, 32'h22222222};
    vecs[9]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h20, 1'b0, 1'b1, 32'h20, 32'h22222222, 1'b0, 1'b1, 32'h22222222};
    vecs[10] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};

    reset = 1'b1;
    drive(1'b1, 32'h40, 32'h5, 1'b1, 32'h40);
    repeat (2) @(posedge clk);
    #1;
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.stall", 32'(cpu_stall), 32'd0);
    check("rst.fwd_hit", 32'(fwd_hit), 32'd0);
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

    // Single store, forwarding priority, stable hold under back-pressure.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ready, vecs[i].ld);
      #1;
      check($sformatf("v%0d.stall", i), 32'(cpu_stall), 32'(vecs[i].stall));
      check($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(vecs[i].mwe));
      check($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].maddr);
      check($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].mwdata);
      check($sformatf("v%0d.empty", i), 32'(empty), 32'(vecs[i].emp));
      check($sformatf("v%0d.fwd_hit", i), 32'(fwd_hit), 32'(vecs[i].hit));
      check($sformatf("v%0d.fwd_data", i), fwd_data, vecs[i].fwd);
      tick();
    end
    check("tbl.log_size", 32'(wr_log.size()), 32'd3);
    check_log("tbl.w0", 0, 32'h10, 32'hDEADBEEF);
    check_log("tbl.w1", 1, 32'h20, 32'h11111111);
    check_log("tbl.w2", 2, 32'h20, 32'h22222222);

    // Fill to DEPTH with memory stalled; the fifth store must wait, and must
    // still stall in the cycle memory first accepts (no full-bypass).
    wr_log.delete();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b0, 32'h0);
      #1;
      check($sformatf("fill%0d.stall", k), 32'(cpu_stall), 32'd0);
      tick();
    end
    drive(1'b1, 32'h10, 32'hA000_0004, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("full%0d.stall", k), 32'(cpu_stall), 32'd1);
      check($sformatf("full%0d.mem_addr", k), mem_addr, 32'h0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("nobypass.stall", 32'(cpu_stall), 32'd1);
    tick();
    #1;
    check("after_drain.stall", 32'(cpu_stall), 32'd0);
    check("after_drain.mem_addr", mem_addr, 32'h4);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    for (int c = 0; c < 20 && !empty; c++) tick();
    check("fill.drained", 32'(empty), 32'd1);
    check("fill.log_size", 32'(wr_log.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      check_log($sformatf("fill.w%0d", k), k, 32'(4 * k), 32'hA000_0000 + 32'(k));

    // Continuous stream with memory always ready: occupancy stays at one and
    // ten writes emerge in order across pointer wrap.
    wr_log.delete();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 32'hB000_0000 + 32'(k), 1'b1, 32'h0);
      #1;
      check($sformatf("strm%0d.stall", k), 32'(cpu_stall), 32'd0);
      if (k > 0) begin
        check($sformatf("strm%0d.mem_addr", k), mem_addr, 32'h100 + 32'(4 * (k - 1)));
        check($sformatf("strm%0d.mem_wdata", k), mem_wdata, 32'hB000_0000 + 32'(k - 1));
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    #1;
    check("strm.last_mem_addr", mem_addr, 32'h124);
    tick();
    check("strm.empty", 32'(empty), 32'd1);
    check("strm.log_size", 32'(wr_log.size()), 32'd10);
    for (int k = 0; k < 10; k++)
      check_log($sformatf("strm.w%0d", k), k, 32'h100 + 32'(4 * k), 32'hB000_0000 + 32'(k));

    // Reset asserted while three stores wait on a stalled memory.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h300 + 32'(4 * k), 32'hC000_0000 + 32'(k), 1'b0, 32'h0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h304);
    #1;
    check("prerst.mem_we", 32'(mem_we), 32'd1);
    check("prerst.fwd_hit", 32'(fwd_hit), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst.mem_we", 32'(mem_we), 32'd0);
    check("midrst.empty", 32'(empty), 32'd1);
    check("midrst.fwd_hit", 32'(fwd_hit), 32'd0);
    check("midrst.mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    wr_log.delete();
    repeat (4) tick();
    check("postrst.log_size", 32'(wr_log.size()), 32'd0);
    check("postrst.mem_we", 32'(mem_we), 32'd0);
    ld_addr = 32'h300;
    #1;
    check("postrst.fwd_hit", 32'(fwd_hit), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
